// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Also provides the helper that builds a frame from a byte.
package uart_pkg;

    typedef enum logic {
        IDLE,
        TRANSMIT
    } tx_state_t;

    localparam int FRAME_BITS       = 10;
    localparam int DEFAULT_BAUD_DIV = 2604;

    // Stop bit in the MSB and start bit in the LSB, so shifting right serialises LSB first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Write-side handshake and serial outputs of the buffered UART transmitter.
// The master side (producer) writes bytes, and the slave side is the transmitter.
interface uart_tx_buf_if;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       TX;
    logic       busy;
    logic       tx_done;

    modport master (
        output wr_en,
        output wr_data,
        input  full,
        input  TX,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output full,
        output TX,
        output busy,
        output tx_done
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers. Reads are first-word fall-through,
// so dout shows the head entry whenever the FIFO is not empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    // Full is evaluated from the current pointers, so a write that coincides with a pop on a full FIFO is dropped.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a two-state framing FSM.
// TX comes from a dedicated flop, so it lags the shift register by one clock.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_buf_if.slave  bus
);

    localparam int             CW          = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0]  BAUD_RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [3:0]     LAST_BIT    = 4'(FRAME_BITS - 1);

    tx_state_t             state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [CW-1:0]         baud_cnt;
    logic [3:0]            bit_cnt;
    logic                  tx_reg;
    logic                  tx_done_reg;
    logic                  pop;
    logic [7:0]            fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign pop = (state == IDLE) && !fifo_empty;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (bus.wr_en),
        .rd_en (pop),
        .din   (bus.wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The single IDLE cycle spent popping is the one idle-high clock between back-to-back frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_reg      <= 1'b1;
            tx_done_reg <= 1'b0;
            shift_reg   <= '1;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
        end else begin
            tx_done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg <= build_frame(fifo_dout);
                        baud_cnt  <= BAUD_RELOAD;
                        bit_cnt   <= '0;
                        state     <= TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    tx_reg <= shift_reg[0];
                    if (baud_cnt == '0) begin
                        shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                        baud_cnt  <= BAUD_RELOAD;
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            tx_done_reg <= 1'b1;
                            state       <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TX      = tx_reg;
    assign bus.tx_done = tx_done_reg;
    assign bus.full    = fifo_full;
    assign bus.busy    = (state == TRANSMIT) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf with BAUD_DIV=16 and depth 4, sampling on falling edges.
// Frames are checked cycle by cycle against a start/data-LSB-first/stop model.
module tb_uart_tx_buf;

    localparam int B     = 16;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * B;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    uart_tx_buf_if bus ();

    uart_tx_buf #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one write so it is sampled by the next rising edge and returns on the following falling edge.
    task automatic applyStimulus(input logic [7:0] d);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Entry happens at falling edge k=startK of a frame, where k=0 is the first falling edge showing the start bit.
    // Exit happens at k=FLEN, which is the idle-high clock. Optionally writes a byte on the edge that pops the next entry.
    task automatic checkFrame(input logic [7:0] data, input int startK, input string name,
                              input bit doWr, input logic [7:0] wrByte, output logic [9:0] seen);
        int   badK;
        int   doneBad;
        logic badTx;
        logic badExp;
        logic doneSeen;
        logic expTx;
        badK     = -1;
        doneBad  = -1;
        badTx    = 1'b0;
        badExp   = 1'b0;
        doneSeen = 1'b0;
        seen     = '1;
        for (int k = startK; k < FLEN; k++) begin
            int bitIdx;
            bitIdx = k / B;
            if (bitIdx == 0)      expTx = 1'b0;
            else if (bitIdx == 9) expTx = 1'b1;
            else                  expTx = data[bitIdx-1];
            if (bus.TX !== expTx && badK < 0) begin
                badK   = k;
                badTx  = bus.TX;
                badExp = expTx;
            end
            if (bus.tx_done !== (k == FLEN - 1) && doneBad < 0) begin
                doneBad  = k;
                doneSeen = bus.tx_done;
            end
            if (k % B == B / 2) seen[bitIdx] = bus.TX;
            if (doWr && k == FLEN - 1) begin
                bus.wr_data = wrByte;
                bus.wr_en   = 1'b1;
            end
            @(negedge clk);
            bus.wr_en = 1'b0;
        end
        checks++;
        if (badK >= 0) begin
            errors++;
            $display("[TB] FAIL %s_bits: cycle %0d TX got %b, expected %b", name, badK, badTx, badExp);
        end
        checks++;
        if (doneBad >= 0) begin
            errors++;
            $display("[TB] FAIL %s_tx_done: cycle %0d got %b, expected %b", name, doneBad, doneSeen, !doneSeen);
        end
    endtask

    // The idle-high clock between back-to-back frames, where the FIFO still holds entries.
    task automatic checkGap(input string name);
        checkOutput({name, "_gap_tx"}, 32'(bus.TX), 32'd1);
        checkOutput({name, "_gap_busy"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        vec_t       vecs [4];
        logic [9:0] seen;
        logic [7:0] burst [4];
        logic [7:0] simul [5];
        int         stray;

        // Line patterns are indexed [0]=start ... [9]=stop.
        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};
        burst   = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        simul   = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h77};

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(bus.TX), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_full", 32'(bus.full), 32'd0);
        checkOutput("reset_tx_done", 32'(bus.tx_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single-byte frames");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].data);
            checkOutput($sformatf("v%0d_busy_after_write", i), 32'(bus.busy), 32'd1);
            @(negedge clk);
            checkOutput($sformatf("v%0d_tx_before_start", i), 32'(bus.TX), 32'd1);
            @(negedge clk);
            checkFrame(vecs[i].data, 0, $sformatf("v%0d", i), 1'b0, 8'h00, seen);
            checkOutput($sformatf("v%0d_pattern", i), 32'(seen), 32'(vecs[i].frame));
            checkOutput($sformatf("v%0d_busy_end", i), 32'(bus.busy), 32'd0);
            checkOutput($sformatf("v%0d_tx_end", i), 32'(bus.TX), 32'd1);
            repeat (3) @(negedge clk);
        end

        $display("[TB] burst of four");
        for (int i = 0; i < 4; i++) applyStimulus(burst[i]);
        checkOutput("burst_full", 32'(bus.full), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkFrame(burst[i], (i == 0) ? 1 : 0, $sformatf("burst%0d", i), 1'b0, 8'h00, seen);
            if (i < 3) checkGap($sformatf("burst%0d", i));
        end
        checkOutput("burst_busy_end", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] overflow");
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i));
        checkOutput("ovf_full_after_4", 32'(bus.full), 32'd0);
        applyStimulus(8'h05);
        checkOutput("ovf_full_after_5", 32'(bus.full), 32'd1);
        applyStimulus(8'h06);
        checkOutput("ovf_full_after_6", 32'(bus.full), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            checkFrame(8'(i), (i == 1) ? 3 : 0, $sformatf("ovf%0d", i), 1'b0, 8'h00, seen);
            if (i < 5) checkGap($sformatf("ovf%0d", i));
        end
        checkOutput("ovf_busy_end", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] write coinciding with pop");
        applyStimulus(8'h11);
        for (int i = 0; i < 4; i++) applyStimulus(simul[i]);
        checkOutput("sim_full_before", 32'(bus.full), 32'd1);
        checkFrame(8'h11, 2, "sim11", 1'b1, 8'h99, seen);
        checkOutput("sim_full_after_drop", 32'(bus.full), 32'd0);
        checkGap("sim11");
        checkFrame(8'h22, 0, "sim22", 1'b1, 8'h77, seen);
        checkOutput("sim_full_after_accept", 32'(bus.full), 32'd0);
        checkGap("sim22");
        for (int i = 1; i < 5; i++) begin
            checkFrame(simul[i], 0, $sformatf("sim%0h", simul[i]), 1'b0, 8'h00, seen);
            if (i < 4) checkGap($sformatf("sim%0h", simul[i]));
        end
        checkOutput("sim_busy_end", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5);
        applyStimulus(8'h5A);
        applyStimulus(8'hC3);
        repeat (4 * B + B / 2) @(negedge clk);
        checkOutput("rst_tx_bit4", 32'(bus.TX), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_tx_async", 32'(bus.TX), 32'd1);
        checkOutput("rst_busy_async", 32'(bus.busy), 32'd0);
        checkOutput("rst_full_async", 32'(bus.full), 32'd0);
        checkOutput("rst_tx_done_async", 32'(bus.tx_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 3 * FLEN; k++) begin
            @(negedge clk);
            if (bus.TX !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) stray++;
        end
        checkOutput("rst_no_frame_after", 32'(stray), 32'd0);

        applyStimulus(8'h3C);
        @(negedge clk);
        @(negedge clk);
        checkFrame(8'h3C, 0, "recover", 1'b0, 8'h00, seen);
        checkOutput("recover_pattern", 32'(seen), 32'(vecs[3].frame));
        checkOutput("recover_busy_end", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
